// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: handshake/data bundle for the single-clock FIFO.
//
// Handshake: WR is a write request, accepted on a rising clk edge only when
// full=0 (full acts as the inverse of ready). RD is a pop request, accepted
// only when empty=0. Q is the head word and is valid whenever empty=0
// (show-ahead). Rejected requests are dropped; the requester must re-assert.
interface fifo_sync_flags_if #(
  parameter int data_width = 8,
  parameter int add_width  = 4
);
  logic                  WR;
  logic                  RD;
  logic [data_width-1:0] D;
  logic [data_width-1:0] Q;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [add_width:0]    count;
  logic                  ovf;
  logic                  unf;

  // Producer/consumer side: drives requests and data, observes status.
  modport master (
    output WR, RD, D,
    input  Q, empty, full, almost_empty, almost_full, count, ovf, unf
  );

  // FIFO side.
  modport slave (
    input  WR, RD, D,
    output Q, empty, full, almost_empty, almost_full, count, ovf, unf
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock show-ahead FIFO, depth = 2**add_width.
// Registered empty/full/almost flags and occupancy count, all updated
// together from the next-state pointers/count.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module fifo_sync_flags #(
  parameter int data_width = 8,
  parameter int add_width  = 4,
  parameter int af_level   = 12,
  parameter int ae_level   = 3
) (
  input logic              clk,
  input logic              srst,
  fifo_sync_flags_if.slave fifo_if
);

  localparam int depth = 1 << add_width;
  localparam logic [add_width:0] one_c = (add_width + 1)'(1);
  localparam logic [add_width:0] af_c  = (add_width + 1)'(af_level);
  localparam logic [add_width:0] ae_c  = (add_width + 1)'(ae_level);

  logic [data_width-1:0] ram_q [depth];

  logic [add_width:0] wr_ptr_q, wr_ptr_d;
  logic [add_width:0] rd_ptr_q, rd_ptr_d;
  logic [add_width:0] count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               ae_q, ae_d;
  logic               af_q, af_d;
  logic               wr_en, rd_en;

  // Requests are qualified by the registered flags from the start of the cycle.
  assign wr_en = fifo_if.WR & ~full_q;
  assign rd_en = fifo_if.RD & ~empty_q;

  // Next-state pointers, count and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + one_c;
    if (rd_en) rd_ptr_d = rd_ptr_q + one_c;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + one_c;
      2'b01:   count_d = count_q - one_c;
      default: count_d = count_q;
    endcase
    // Pointers carry one extra MSB so equal-low-bits can mean empty or full.
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[add_width] != rd_ptr_d[add_width]) &&
              (wr_ptr_d[add_width-1:0] == rd_ptr_d[add_width-1:0]);
    ae_d    = (count_d <= ae_c);
    af_d    = (count_d >= af_c);
  end

  // Pointer, count and flag registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
    end
  end

  // Storage write; contents are never cleared, a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !srst) begin
      ram_q[wr_ptr_q[add_width-1:0]] <= fifo_if.D;
    end
  end

  // Show-ahead head word.
  assign fifo_if.Q            = ram_q[rd_ptr_q[add_width-1:0]];
  assign fifo_if.empty        = empty_q;
  assign fifo_if.full         = full_q;
  assign fifo_if.almost_empty = ae_q;
  assign fifo_if.almost_full  = af_q;
  assign fifo_if.count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags: any rejected request sets them until reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (fifo_if.WR && full_q)  ovf_q <= 1'b1;
      if (fifo_if.RD && empty_q) unf_q <= 1'b1;
    end
  end

  assign fifo_if.ovf = ovf_q;
  assign fifo_if.unf = unf_q;
`else
  assign fifo_if.ovf = 1'b0;
  assign fifo_if.unf = 1'b0;
`endif

endmodule
